// File: rtl/ysyx_22041211_lsu_ctrl_pkg.sv
// Shared encodings for the load/store controller: access types, FSM states
// and the word-alignment helper used for bus addresses.
package ysyx_22041211_lsu_ctrl_pkg;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'b000,
    LOAD_LB   = 3'b001,
    LOAD_LH   = 3'b010,
    LOAD_LW   = 3'b011,
    LOAD_LBU  = 3'b100,
    LOAD_LHU  = 3'b101
  } load_type_e;

  typedef enum logic [1:0] {
    STORE_NONE = 2'b00,
    STORE_SB   = 2'b01,
    STORE_SH   = 2'b10,
    STORE_SW   = 2'b11
  } store_type_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Byte-lane logic for the LSU: store strobes and data shift, load extraction
// with sign/zero extension, and the natural-alignment check.
module ysyx_22041211_lsu_align
  import ysyx_22041211_lsu_ctrl_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        is_store,
  output logic        is_load,
  output logic        misaligned,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  function automatic logic [31:0] sext8(input logic [7:0] b);
    logic signed [7:0] s;
    s = b;
    return 32'(s);
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    logic signed [15:0] s;
    s = h;
    return 32'(s);
  endfunction

  logic [1:0]  off;
  logic [31:0] rshift;

  assign off    = addr[1:0];
  assign rshift = rdata >> {off, 3'b000};

  always_comb begin
    // A store type takes precedence; the load type is then ignored.
    is_store   = store_type != STORE_NONE;
    is_load    = !is_store && (load_type != LOAD_NONE);
    misaligned = 1'b0;
    wstrb      = 4'b0000;
    wdata_sh   = '0;
    rdata_ext  = '0;
    if (is_store) begin
      wdata_sh = wdata << {off, 3'b000};
      case (store_type_e'(store_type))
        STORE_SB: wstrb = 4'b0001 << off;
        STORE_SH: begin
          wstrb      = 4'b0011 << off;
          misaligned = off[0];
        end
        default: begin
          wstrb      = 4'b1111;
          misaligned = off != 2'b00;
        end
      endcase
    end else if (is_load) begin
      case (load_type_e'(load_type))
        LOAD_LB:  rdata_ext = sext8(rshift[7:0]);
        LOAD_LBU: rdata_ext = {24'b0, rshift[7:0]};
        LOAD_LH: begin
          rdata_ext  = sext16(rshift[15:0]);
          misaligned = off[0];
        end
        LOAD_LHU: begin
          rdata_ext  = {16'b0, rshift[15:0]};
          misaligned = off[0];
        end
        default: begin
          rdata_ext  = rshift;
          misaligned = off != 2'b00;
        end
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22041211_lsu_ctrl.sv
// Multi-cycle load/store controller between EXE and the data bus: one access
// at a time, request/response handshake with a bounded response wait.
module ysyx_22041211_lsu_ctrl
  import ysyx_22041211_lsu_ctrl_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [2:0]          load_type_i,
  input  logic [1:0]          store_type_i,
  input  logic [DATA_LEN-1:0] addr_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  output logic                busy_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic                mem_we_o,
  output logic [DATA_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [3:0]          mem_wstrb_o,
  input  logic                mem_rsp_valid_i,
  input  logic [DATA_LEN-1:0] mem_rdata_i,
  output logic                done_o,
  output logic [DATA_LEN-1:0] rdata_o,
  output logic                err_o
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT);

  lsu_state_e          state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                err_q, err_d;

  logic [DATA_LEN-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]          load_q;
  logic [1:0]          store_q;

  logic                accept;
  logic [2:0]          al_load;
  logic [1:0]          al_store;
  logic [DATA_LEN-1:0] al_addr, al_wdata_in;
  logic                al_is_store, al_is_load, al_misaligned;
  logic [3:0]          al_wstrb;
  logic [DATA_LEN-1:0] al_wdata, al_rdata;

  assign accept = (state_q == LSU_IDLE) && in_valid_i;

  // In IDLE the aligner classifies the offered op; afterwards it works on the latched op.
  assign al_load     = (state_q == LSU_IDLE) ? load_type_i  : load_q;
  assign al_store    = (state_q == LSU_IDLE) ? store_type_i : store_q;
  assign al_addr     = (state_q == LSU_IDLE) ? addr_i       : addr_q;
  assign al_wdata_in = (state_q == LSU_IDLE) ? wdata_i      : wdata_q;

  ysyx_22041211_lsu_align u_align (
    .load_type  (al_load),
    .store_type (al_store),
    .addr       (al_addr),
    .wdata      (al_wdata_in),
    .rdata      (mem_rdata_i),
    .is_store   (al_is_store),
    .is_load    (al_is_load),
    .misaligned (al_misaligned),
    .wstrb      (al_wstrb),
    .wdata_sh   (al_wdata),
    .rdata_ext  (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    case (state_q)
      LSU_IDLE: begin
        if (in_valid_i) begin
          err_d = 1'b0;
          if (!al_is_store && !al_is_load) begin
            state_d = LSU_DONE;
          end else if (al_misaligned) begin
            state_d = LSU_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        if (mem_req_ready_i) begin
          state_d = LSU_WAIT;
          timer_d = '0;
        end
      end
      LSU_WAIT: begin
        // A response in the same cycle the limit is reached still completes normally.
        if (mem_rsp_valid_i) begin
          state_d = LSU_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
          if (timer_d == TIMER_LIMIT) begin
            state_d = LSU_DONE;
            err_d   = 1'b1;
          end
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      load_q  <= load_type_i;
      store_q <= store_type_i;
      rdata_q <= '0;
    end else if ((state_q == LSU_WAIT) && mem_rsp_valid_i && al_is_load) begin
      rdata_q <= al_rdata;
    end
  end

  // Data outputs are gated by state so they read zero whenever they carry nothing.
  assign in_ready_o      = state_q == LSU_IDLE;
  assign busy_o          = state_q != LSU_IDLE;
  assign mem_req_valid_o = state_q == LSU_REQ;
  assign mem_we_o        = mem_req_valid_o && al_is_store;
  assign mem_addr_o      = mem_req_valid_o ? word_align(addr_q) : '0;
  assign mem_wdata_o     = mem_req_valid_o ? al_wdata : '0;
  assign mem_wstrb_o     = mem_req_valid_o ? al_wstrb : 4'b0000;
  assign done_o          = state_q == LSU_DONE;
  assign rdata_o         = done_o ? rdata_q : '0;
  assign err_o           = done_o && err_q;

endmodule

// File: tb/tb_ysyx_22041211_lsu_ctrl.sv
// Scoreboard bench for the LSU controller: randomized ops against a byte-lane
// reference model, with a reactive bus model and directed corner cases.
module tb_ysyx_22041211_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rdata_i;
  logic        done_o, err_o;
  logic [31:0] rdata_o;

  ysyx_22041211_lsu_ctrl #(.DATA_LEN(32), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .load_type_i     (load_type_i),
    .store_type_i    (store_type_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .busy_o          (busy_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_wstrb_o     (mem_wstrb_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rdata_i     (mem_rdata_i),
    .done_o          (done_o),
    .rdata_o         (rdata_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          stall;
    int          delay;
    bit          drop;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];
  int    vectors = 0;
  int    errors = 0;
  int    cyc = 0;
  int    accept_cyc = 0;
  bit    late_rsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: event not expected / bound expired", name);
  endtask

  // Bus memory contents: a fixed word at the base, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h12F0_3456;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Reference: access size from the type, natural alignment, lane shift, extension.
  function automatic void model(input logic [2:0] lt, input logic [1:0] st,
                                input logic [31:0] a, input logic [31:0] wd,
                                output bit has_req, output req_t r, output done_t d);
    int          off, sz, m;
    bit          sgn;
    logic [31:0] v, mask;
    off = int'(a[1:0]);
    sz = 0;
    sgn = 0;
    has_req = 0;
    d.rdata = '0; d.err = 1'b0; d.lat = 0;
    r.we = 1'b0; r.addr = {a[31:2], 2'b00}; r.wstrb = '0; r.wdata = '0;
    r.stall = 0; r.delay = 0; r.drop = 0;
    if (st != 2'd0) begin
      sz = (st == 2'd1) ? 1 : (st == 2'd2) ? 2 : 4;
      r.we = 1'b1;
    end else begin
      case (lt)
        3'd1: begin sz = 1; sgn = 1; end
        3'd2: begin sz = 2; sgn = 1; end
        3'd3: sz = 4;
        3'd4: sz = 1;
        3'd5: sz = 2;
        default: sz = 0;
      endcase
    end
    if (sz == 0) return;
    if ((off % sz) != 0) begin
      d.err = 1'b1;
      return;
    end
    has_req = 1;
    if (r.we) begin
      m = ((1 << sz) - 1) << off;
      r.wstrb = 4'(m);
      r.wdata = wd << (8 * off);
    end else begin
      v = mem_word(r.addr) >> (8 * off);
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v = v & mask;
      if (sgn && v[8 * sz - 1]) v = v | ~mask;
      d.rdata = v;
    end
  endfunction

  // Called on a falling edge; returns on a falling edge.
  task automatic issue(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] a,
                       input logic [31:0] wd, input bit has_req, input req_t r, input done_t d);
    int guard;
    load_type_i = lt;
    store_type_i = st;
    addr_i = a;
    wdata_i = wd;
    in_valid_i = 1'b1;
    if (has_req) req_q.push_back(r);
    done_q.push_back(d);
    guard = 0;
    while (!in_ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready_o) fail("accept_timeout");
    accept_cyc = cyc;
    @(negedge clk);
    // A stray offer while busy must be ignored.
    load_type_i = 3'($urandom);
    store_type_i = 2'($urandom);
    addr_i = $urandom;
    wdata_i = $urandom;
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic send(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] a,
                      input logic [31:0] wd, input int stall, input int delay, input bit drop);
    bit    has_req;
    req_t  r;
    done_t d;
    model(lt, st, a, wd, has_req, r, d);
    r.stall = stall;
    r.delay = delay;
    r.drop = drop;
    if (!has_req) d.lat = 1;
    else if (drop) begin
      d.rdata = '0;
      d.err = 1'b1;
      d.lat = 3 + stall + (TO - 1);
    end else d.lat = 3 + stall + delay;
    issue(lt, st, a, wd, has_req, r, d);
  endtask

  task automatic send_exp(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] a,
                          input logic [31:0] wd, input bit has_req, input logic we,
                          input logic [31:0] maddr, input logic [3:0] strb, input logic [31:0] mwd,
                          input logic [31:0] rd, input logic err, input int lat,
                          input int stall, input int delay, input bit drop);
    req_t  r;
    done_t d;
    r.we = we; r.addr = maddr; r.wstrb = strb; r.wdata = mwd;
    r.stall = stall; r.delay = delay; r.drop = drop;
    d.rdata = rd; d.err = err; d.lat = lat;
    issue(lt, st, a, wd, has_req, r, d);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_req_valid"}, 32'(mem_req_valid_o), 32'd0);
    check({tag, "_we"}, 32'(mem_we_o), 32'd0);
    check({tag, "_addr"}, mem_addr_o, 32'd0);
    check({tag, "_wdata"}, mem_wdata_o, 32'd0);
    check({tag, "_wstrb"}, 32'(mem_wstrb_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_rdata"}, rdata_o, 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  // Bus model: checks each request against the scoreboard, stalls, responds.
  initial begin
    bit          in_req, hs, pending, prev_stalled;
    int          stall, delay;
    req_t        cur;
    logic [31:0] rsp_addr, p_addr, p_wdata;
    logic [3:0]  p_wstrb;
    logic        p_we;
    in_req = 0; hs = 0; pending = 0; prev_stalled = 0;
    stall = 0; delay = 0; rsp_addr = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid_i = 1'b0;
      mem_rdata_i = $urandom;
      if (rst) begin
        in_req = 0; hs = 0; pending = 0; prev_stalled = 0;
        mem_req_ready_i = 1'($urandom_range(0, 1));
      end else begin
        if (late_rsp) mem_rsp_valid_i = 1'b1;
        if (hs) begin
          hs = 0;
          if (!cur.drop) begin
            pending = 1;
            delay = cur.delay;
          end
        end
        if (pending) begin
          if (delay == 0) begin
            mem_rsp_valid_i = 1'b1;
            mem_rdata_i = mem_word(rsp_addr);
            pending = 0;
          end else delay--;
        end
        if (prev_stalled) begin
          check("req_hold_valid", 32'(mem_req_valid_o), 32'd1);
          check("req_hold_addr", mem_addr_o, p_addr);
          check("req_hold_wdata", mem_wdata_o, p_wdata);
          check("req_hold_wstrb", 32'(mem_wstrb_o), 32'(p_wstrb));
          check("req_hold_we", 32'(mem_we_o), 32'(p_we));
        end
        prev_stalled = 0;
        if (mem_req_valid_o) begin
          if (!in_req) begin
            check("req_busy", 32'(busy_o), 32'd1);
            if (req_q.size() == 0) begin
              fail("unexpected_req");
              cur.we = mem_we_o; cur.addr = mem_addr_o; cur.wstrb = mem_wstrb_o;
              cur.wdata = mem_wdata_o; cur.stall = 0; cur.delay = 0; cur.drop = 0;
            end else begin
              cur = req_q.pop_front();
              check("req_we", 32'(mem_we_o), 32'(cur.we));
              check("req_addr", mem_addr_o, cur.addr);
              check("req_wstrb", 32'(mem_wstrb_o), 32'(cur.wstrb));
              if (cur.we) check("req_wdata", mem_wdata_o, cur.wdata);
            end
            in_req = 1;
            stall = cur.stall;
          end
          if (stall > 0) begin
            stall--;
            mem_req_ready_i = 1'b0;
            prev_stalled = 1;
            p_addr = mem_addr_o; p_wdata = mem_wdata_o; p_wstrb = mem_wstrb_o; p_we = mem_we_o;
          end else begin
            mem_req_ready_i = 1'b1;
            in_req = 0;
            hs = 1;
            rsp_addr = mem_addr_o;
          end
        end else begin
          mem_req_ready_i = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst && done_o) begin
        if (done_q.size() == 0) fail("unexpected_done");
        else begin
          d = done_q.pop_front();
          check("done_rdata", rdata_o, d.rdata);
          check("done_err", 32'(err_o), 32'(d.err));
          check("done_busy", 32'(busy_o), 32'd1);
          if (d.lat > 0) check("done_latency", 32'(cyc - accept_cyc), 32'(d.lat));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          guard, kind, stall;
    logic [2:0]  lt;
    logic [1:0]  st;
    rst = 1'b1;
    in_valid_i = 1'b0;
    load_type_i = '0;
    store_type_i = '0;
    addr_i = '0;
    wdata_i = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    #2 rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-computed expectations.
    send_exp(3'd0, 2'd3, 32'h8000_0008, 32'hDEAD_BEEF, 1, 1'b1, 32'h8000_0008, 4'b1111,
             32'hDEAD_BEEF, 32'h0, 1'b0, 3, 0, 0, 0);
    send_exp(3'd0, 2'd1, 32'h8000_0003, 32'h0000_00A5, 1, 1'b1, 32'h8000_0000, 4'b1000,
             32'hA500_0000, 32'h0, 1'b0, 3, 0, 0, 0);
    send_exp(3'd1, 2'd0, 32'h8000_0002, 32'h0, 1, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,
             32'hFFFF_FFF0, 1'b0, 3, 0, 0, 0);
    send_exp(3'd4, 2'd0, 32'h8000_0002, 32'h0, 1, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,
             32'h0000_00F0, 1'b0, 3, 0, 0, 0);
    send_exp(3'd2, 2'd0, 32'h8000_0002, 32'h0, 1, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,
             32'h0000_12F0, 1'b0, 3, 0, 0, 0);
    send_exp(3'd5, 2'd0, 32'h8000_0002, 32'h0, 1, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,
             32'h0000_12F0, 1'b0, 3, 0, 0, 0);
    send_exp(3'd3, 2'd0, 32'h8000_0002, 32'h0, 0, 1'b0, 32'h0, 4'b0000, 32'h0,
             32'h0, 1'b1, 1, 0, 0, 0);
    send_exp(3'd0, 2'd2, 32'h8000_0006, 32'hCAFE_1234, 1, 1'b1, 32'h8000_0004, 4'b1100,
             32'h1234_0000, 32'h0, 1'b0, 8, 5, 0, 0);
    send_exp(3'd3, 2'd0, 32'h8000_0010, 32'h0, 1, 1'b0, 32'h8000_0010, 4'b0000, 32'h0,
             32'h0, 1'b1, 6, 0, 0, 1);
    send_exp(3'd0, 2'd0, 32'h8000_0044, 32'h0, 0, 1'b0, 32'h0, 4'b0000, 32'h0,
             32'h0, 1'b0, 1, 0, 0, 0);
    send_exp(3'd1, 2'd3, 32'h8000_0020, 32'h1122_3344, 1, 1'b1, 32'h8000_0020, 4'b1111,
             32'h1122_3344, 32'h0, 1'b0, 3, 0, 0, 0);
    send(3'd3, 2'd0, 32'h8000_0014, 32'h0, 0, TO - 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        lt = 3'd0; st = 2'd0;
      end else if (kind <= 4) begin
        st = 2'($urandom_range(1, 3)); lt = 3'($urandom);
      end else begin
        st = 2'd0; lt = 3'($urandom_range(1, 5));
      end
      stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
      send(lt, st, 32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom, stall,
           $urandom_range(0, TO - 1), $urandom_range(0, 11) == 0);
    end

    guard = 0;
    while (done_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (done_q.size() != 0) fail("drain_timeout");

    // Reset in WAIT: outputs drop at once and a late response is ignored.
    send(3'd3, 2'd0, 32'h8000_0030, 32'h0, 0, 0, 1);
    check("wait_busy", 32'(busy_o), 32'd1);
    check("wait_req_valid", 32'(mem_req_valid_o), 32'd0);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_rst");
    req_q.delete();
    done_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    late_rsp = 1;
    repeat (3) @(negedge clk);
    late_rsp = 0;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_done", 32'(done_o), 32'd0);
      check("post_rst_ready", 32'(in_ready_o), 32'd1);
      @(negedge clk);
    end
    send_exp(3'd0, 2'd3, 32'h8000_0040, 32'h0BAD_F00D, 1, 1'b1, 32'h8000_0040, 4'b1111,
             32'h0BAD_F00D, 32'h0, 1'b0, 3, 0, 0, 0);
    guard = 0;
    while (done_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (done_q.size() != 0) fail("final_drain_timeout");
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
